// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline types: per-stage request/control records, decode info, stage indices
// and the pipe_ctrl FSM state encoding.
package pipe_ctrl_pkg;

  localparam int NUM_STAGES = 5;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB = 4;

  typedef struct packed {
    logic                  stall_req;
    logic [NUM_STAGES-1:0] flush_req;
  } PipeRequest;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       enable;
    logic       mem_read;
    logic       rd_valid;
    logic [4:0] rd;
    logic       rs1_valid;
    logic [4:0] rs1;
    logic       rs2_valid;
    logic [4:0] rs2;
  } DecodeInfo;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_DRAIN
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-facing bundle of pipe_ctrl: requests and decode/execute info in, per-stage control out.
// The stages (master) drive requests; the controller (slave) answers combinationally.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NUM_STAGES
);
  PipeRequest [NSTAGE-1:0] req_i;
  DecodeInfo               id_info;
  DecodeInfo               ex_info;
  PipeControl [NSTAGE-1:0] ctl_o;

  modport master(output req_i, output id_info, output ex_info, input ctl_o);
  modport slave(input req_i, input id_info, input ex_info, output ctl_o);
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter; synchronous clear has priority over increment.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with load-use detection, deferred flush replay,
// performance counters and stall watchdog. Control outputs are zero-latency (combinational).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE  = NUM_STAGES,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus,
  output logic             load_use,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  input  logic             clr_counters
);

  localparam int RUN_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  pipe_state_e       state_q;
  logic [NSTAGE-1:0] pend_q, pend_d;
  logic [NSTAGE-1:0] raw, stall_src, stall, flush;
  logic [RUN_W-1:0]  run_cnt;
  logic              hazard, hazard_eff, any_stall, any_flush;

  assign hazard = bus.ex_info.enable && bus.ex_info.mem_read && bus.ex_info.rd_valid &&
                  (bus.ex_info.rd != 5'd0) && bus.id_info.enable &&
                  ((bus.id_info.rs1_valid && (bus.id_info.rs1 == bus.ex_info.rd)) ||
                   (bus.id_info.rs2_valid && (bus.id_info.rs2 == bus.ex_info.rd)));

  always_comb begin
    // Pending bits only exist after a stall, i.e. while the FSM is out of RUN.
    raw = (state_q != ST_RUN) ? pend_q : '0;
    for (int j = 0; j < NSTAGE; j++) raw |= bus.req_i[j].flush_req;
    // A flush of decode kills the dependent instruction, so no bubble is needed.
    hazard_eff = hazard && !raw[STG_ID];
    for (int j = 0; j < NSTAGE; j++)
      stall_src[j] = bus.req_i[j].stall_req || ((j == STG_ID) && hazard_eff);
    for (int i = 0; i < NSTAGE; i++) stall[i] = |(stall_src >> i);
    for (int k = 0; k < NSTAGE; k++) begin
      flush[k]  = !stall[k] && (raw[k] || ((k == STG_EX) && hazard_eff));
      pend_d[k] = stall[k] && raw[k];
    end
  end

  always_comb begin
    for (int i = 0; i < NSTAGE; i++) begin
      bus.ctl_o[i].stall = rst && stall[i];
      bus.ctl_o[i].flush = rst && flush[i];
    end
  end

  assign load_use  = rst && hazard_eff && !stall[STG_EX];
  assign any_stall = stall[0];
  assign any_flush = |flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      pend_q        <= '0;
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        ST_RUN:   if (any_stall) state_q <= ST_HOLD;
        ST_HOLD:  if (!any_stall) state_q <= (pend_q != '0) ? ST_DRAIN : ST_RUN;
        ST_DRAIN: state_q <= any_stall ? ST_HOLD : ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
      if (!any_stall) run_cnt <= '0;
      else if (run_cnt != RUN_W'(TIMEOUT - 1)) run_cnt <= run_cnt + 1'b1;
      if (clr_counters) stall_timeout <= 1'b0;
      else if (any_stall && (run_cnt == RUN_W'(TIMEOUT - 1))) stall_timeout <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(any_stall), .clr(clr_counters), .cnt(stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(any_flush), .clr(clr_counters), .cnt(flush_events)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog timeout.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_counters = 1'b0;
  logic        load_use, stall_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic [4:0]  st_v, fl_v;
  int          checks = 0;
  int          failures = 0;

  pipe_ctrl_if #(.NSTAGE(5)) bus ();

  pipe_ctrl #(.NSTAGE(5), .TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .load_use(load_use),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
    .flush_events(flush_events), .clr_counters(clr_counters)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      st_v[i] = bus.ctl_o[i].stall;
      fl_v[i] = bus.ctl_o[i].flush;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_i   = '0;
    bus.id_info = '0;
    bus.ex_info = '0;
  endtask

  task automatic set_hazard();
    bus.ex_info = '{enable: 1'b1, mem_read: 1'b1, rd_valid: 1'b1, rd: 5'd5, default: '0};
    bus.id_info = '{enable: 1'b1, rs1_valid: 1'b1, rs1: 5'd5, rs2_valid: 1'b1, rs2: 5'd1,
                    default: '0};
  endtask

  task automatic clear_counters();
    clr_counters = 1'b1;
    tick();
    clr_counters = 1'b0;
  endtask

  initial begin
    idle();
    #3;
    check("reset_stall", st_v, 5'b0);
    check("reset_flush", fl_v, 5'b0);
    check("reset_load_use", load_use, 1'b0);
    check("reset_counters", {stall_cycles, flush_events}, 64'd0);
    check("reset_timeout", stall_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Load-use: LW x5 in execute, ADD x6,x5,x1 in decode.
    set_hazard();
    @(negedge clk);
    check("lu_stall", st_v, 5'b00011);
    check("lu_flush", fl_v, 5'b00100);
    check("lu_load_use", load_use, 1'b1);
    tick();
    bus.ex_info = '0;
    @(negedge clk);
    check("lu_after_ctl", {st_v, fl_v, 4'b0, load_use}, 0);
    tick();
    check("lu_counters", {stall_cycles, flush_events}, {32'd1, 32'd1});
    idle();
    clear_counters();
    check("clr_counters", {stall_cycles, flush_events}, 64'd0);

    // Memory stall for three cycles.
    bus.req_i[STG_MEM].stall_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mem_stall_c%0d", c), {fl_v, st_v}, {5'b0, 5'b01111});
      tick();
    end
    idle();
    check("mem_stall_cycles", stall_cycles, 32'd3);
    clear_counters();

    // Branch flush arrives while writeback stalls; replayed on release.
    bus.req_i[STG_WB].stall_req = 1'b1;
    bus.req_i[STG_EX].flush_req = 5'b00111;
    @(negedge clk);
    check("defer_c0", {st_v, fl_v}, {5'b11111, 5'b0});
    tick();
    bus.req_i[STG_EX].flush_req = '0;
    @(negedge clk);
    check("defer_c1", {st_v, fl_v}, {5'b11111, 5'b0});
    tick();
    idle();
    @(negedge clk);
    check("defer_replay", {st_v, fl_v}, {5'b0, 5'b00111});
    tick();
    @(negedge clk);
    check("defer_once", fl_v, 5'b0);
    check("defer_counters", {stall_cycles, flush_events}, {32'd2, 32'd1});
    tick();

    // Branch flush and load-use in the same cycle: the flush wins.
    set_hazard();
    bus.req_i[STG_EX].flush_req = 5'b00111;
    @(negedge clk);
    check("br_lu_ctl", {st_v, fl_v}, {5'b0, 5'b00111});
    check("br_lu_load_use", load_use, 1'b0);
    tick();
    idle();
    clear_counters();

    // Watchdog: timeout 8.
    bus.req_i[STG_IF].stall_req = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    check("wd_before", stall_timeout, 1'b0);
    tick();
    check("wd_set", stall_timeout, 1'b1);
    check("wd_stall_cycles", stall_cycles, 32'd8);
    idle();
    tick();
    check("wd_sticky", stall_timeout, 1'b1);
    clear_counters();
    check("wd_clr", {31'd0, stall_timeout, stall_cycles}, 64'd0);

    // Async reset while holding a pending flush.
    bus.req_i[STG_WB].stall_req = 1'b1;
    bus.req_i[STG_EX].flush_req = 5'b00011;
    @(negedge clk);
    check("ar_pend_ctl", {st_v, fl_v}, {5'b11111, 5'b0});
    tick();
    bus.req_i[STG_EX].flush_req = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_ctl_zero", {st_v, fl_v, 4'b0, load_use}, 0);
    check("ar_counters", {stall_cycles, flush_events}, 64'd0);
    #1;
    rst = 1'b1;
    tick();
    idle();
    @(negedge clk);
    check("ar_no_replay", {st_v, fl_v}, 10'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
